gate_stim_seq: RTL and testbench
================================

// Module: gate_stim_seq
// PURPOSE
//  - Upstream stimulus sequencer for the gate-primitive cosim harnesses (pmos/nmos/cmos specs).
//  - Produces a bounded stream of WIDTH-bit input vectors over a valid/ready handshake.
//  - The harness applies each vector to the spec's 'in' bus and records the spec's 'out' bus.
//  - Sequence: two directed corner vectors, then pseudo-random vectors from a 32-bit Galois LFSR.
// PARAMETERS
//  WIDTH  128           vector width; must be a multiple of 32
//  NVEC   256           vectors per run; legal range 2..65535
//  SEED   32'h00000001  LFSR seed loaded on start; must be nonzero
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous reset, active high
//  start      in   1      begin a run; sampled only in IDLE and DONE
//  busy       out  1      high while in RUN
//  done       out  1      sticky; high in DONE until the next start
//  vec_valid  out  1      vec_out/vec_idx hold a vector to consume
//  vec_ready  in   1      consumer accepts the vector when vec_valid && vec_ready
//  vec_out    out  WIDTH  stimulus vector
//  vec_idx    out  16     index of vec_out within the run, 0..NVEC-1
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; busy=done=vec_valid=0; vec_out=0; vec_idx=0; lfsr=SEED.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, start=1: next cycle RUN, vec_idx=0, vec_valid=1, vec_out=all zeros, lfsr=SEED.
//  - RUN: vec_valid=1 continuously. Each acceptance (valid&&ready) advances vec_idx by 1 next cycle.
//  - RUN, no acceptance: vec_out, vec_idx and lfsr hold exactly; no glitching while stalled.
//  - Vector contents by index:
//    - idx0 = all zeros; idx1 = all ones.
//    - idx>=2: concat of WIDTH/32 successive LFSR states, {s[K-1],...,s1,s0}; s0 in bits[31:0].
//    - s0 = current lfsr; s(k+1) = step(s(k)).
//  - LFSR: step(s) = s[0] ? (s>>1)^32'h80200003 : (s>>1).
//  - On accepting an idx>=2 vector, lfsr <= step(s[K-1]). lfsr does not advance for idx0/idx1.
//  - Last vector: accepting vec_idx==NVEC-1 -> DONE next cycle; vec_valid=0, busy=0, done=1.
//    - vec_out and vec_idx keep their last values.
//  - DONE, start=1: restart exactly as from IDLE (done drops the same cycle vec_valid rises).
//  - Ignored inputs:
//    - start in RUN is ignored; the run is not restarted.
//    - vec_ready is ignored outside RUN.
//  - Latency: start to first vec_valid = 1 cycle. Back-to-back acceptance sustains 1 vector/cycle.
//  - Reset asserted mid-run: the run is abandoned with no partial completion; done stays 0.
//  - vec_idx is 16 bits and never wraps because NVEC<=65535.
// CONFIGURATION
//  - GATE_STIM_XZ_EN defined: 4-state injection for switch-level primitives.
//    - Applies to vectors with idx>=2 and idx[2:0]==3'b111.
//    - Those vectors get vec_out[0]=1'bz (data) and vec_out[1]=1'bx (gate control); other bits unchanged.
//    - lfsr advance is unaffected.
//  - GATE_STIM_XZ_EN undefined: vec_out is strictly 2-state; no x/z is ever driven.
// TESTING
//  1. Reset during RUN at idx 5: all outputs 0 immediately (async); after deassert FSM=IDLE, no vec_valid.
//  2. NVEC=4, SEED=1, ready tied 1: idx0=0, idx1=all ones, then done=1 one cycle after idx3 is accepted.
//     - idx2[63:0] = 64'h80200003_00000001.
//  3. ready held 0 for 3 cycles at idx2: vec_out/vec_idx stable throughout; idx3 appears the cycle after ready=1.
//  4. start pulsed in RUN at idx1: run continues unchanged; start in DONE restarts with idx0=0, lfsr=SEED.
//  5. NVEC=2: exactly two vectors (zeros, ones); lfsr still equals SEED at DONE.
//  6. GATE_STIM_XZ_EN, NVEC=16: idx7 and idx15 have bit0=z, bit1=x; idx8 matches the undefined-macro build.

Source files
------------

// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for the gate-primitive cosim harnesses: two corner vectors, then Galois-LFSR vectors over valid/ready.
// Optional 4-state x/z injection on every eighth LFSR vector is enabled by defining GATE_STIM_XZ_EN.
module gate_stim_seq #(
    parameter int          WIDTH = 128,
    parameter int          NVEC  = 256,
    parameter logic [31:0] SEED  = 32'h00000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [WIDTH-1:0] vec_out,
    output logic [15:0]      vec_idx
);

    localparam int          K    = WIDTH / 32;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam logic [15:0] LAST = 16'(NVEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      lfsr_reg, lfsr_next;
    logic [WIDTH-1:0] vec_reg, vec_next;
    logic [15:0]      idx_reg, idx_next;

    // chain[0..K-1] builds the vector for the current lfsr; chain[K..2K-1] the one after it.
    logic [31:0]      chain [0:2*K-1];
    logic [WIDTH-1:0] cur_vec;
    logic [WIDTH-1:0] adv_vec;

    assign chain[0] = lfsr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2*K-1; gi++) begin : g_chain
            assign chain[gi+1] = chain[gi][0] ? ({1'b0, chain[gi][31:1]} ^ POLY)
                                              : {1'b0, chain[gi][31:1]};
        end
        for (gi = 0; gi < K; gi++) begin : g_words
            assign cur_vec[gi*32 +: 32] = chain[gi];
            assign adv_vec[gi*32 +: 32] = chain[K+gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED;
            vec_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            vec_reg   <= vec_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        vec_next   = vec_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = '0;
                    vec_next   = '0;
                    lfsr_next  = SEED;
                end
            end
            RUN: begin
                if (vec_ready) begin
                    // Corner vectors leave the LFSR untouched; LFSR vectors consume K states.
                    if (idx_reg >= 16'd2) begin
                        lfsr_next = chain[K];
                    end
                    if (idx_reg == LAST) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 16'd1;
                        if (idx_reg == 16'd0) begin
                            vec_next = '1;
                        end else if (idx_reg == 16'd1) begin
                            vec_next = cur_vec;
                        end else begin
                            vec_next = adv_vec;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg == RUN);
    assign vec_valid = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign vec_idx   = idx_reg;

`ifdef GATE_STIM_XZ_EN
    // Overlay keyed on the held index, so a stalled or final vector keeps its x/z bits.
    logic xz_hit;
    assign xz_hit  = (idx_reg >= 16'd2) && (idx_reg[2:0] == 3'b111);
    assign vec_out = xz_hit ? {vec_reg[WIDTH-1:2], 1'bx, 1'bz} : vec_reg;
`else
    assign vec_out = vec_reg;
`endif

endmodule

// File: tb/tb_gate_stim_seq.sv
// Scoreboarded bench for gate_stim_seq: NVEC=16 instance for stalls/restarts/reset, NVEC=2 instance for the minimal run.
module tb_gate_stim_seq;

    localparam int          W    = 128;
    localparam int          K    = W / 32;
    localparam int          NA   = 16;
    localparam logic [31:0] SEED = 32'h00000001;

    typedef struct packed {
        logic [15:0]  idx;
        logic [W-1:0] vec;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_start, a_busy, a_done, a_valid, a_ready;
    logic [W-1:0] a_vec;
    logic [15:0]  a_idx;
    logic         b_start, b_busy, b_done, b_valid, b_ready;
    logic [W-1:0] b_vec;
    logic [15:0]  b_idx;

    entry_t sb[$];
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    gate_stim_seq #(.WIDTH(W), .NVEC(NA), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .vec_valid(a_valid), .vec_ready(a_ready), .vec_out(a_vec), .vec_idx(a_idx)
    );

    gate_stim_seq #(.WIDTH(W), .NVEC(2), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .vec_valid(b_valid), .vec_ready(b_ready), .vec_out(b_vec), .vec_idx(b_idx)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_run(input int n);
        logic [31:0] s;
        entry_t      e;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            e.idx = 16'(i);
            if (i == 0) begin
                e.vec = '0;
            end else if (i == 1) begin
                e.vec = '1;
            end else begin
                for (int k = 0; k < K; k++) begin
                    e.vec[k*32 +: 32] = s;
                    s = step(s);
                end
`ifdef GATE_STIM_XZ_EN
                if (i[2:0] == 3'b111) begin
                    e.vec[0] = 1'bz;
                    e.vec[1] = 1'bx;
                end
`endif
            end
            sb.push_back(e);
        end
    endtask

    // Random-ready consumer: pops and compares every accepted vector; stops at stop_idx or end of run.
    task automatic drain(input int stop_idx, output entry_t last);
        entry_t e;
        last = '0;
        for (int c = 0; c < 400; c++) begin
            if (!a_valid) break;
            if (stop_idx >= 0 && int'(a_idx) == stop_idx) break;
            a_ready = 1'($urandom_range(0, 1));
            if (a_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_vector", W'(a_idx), W'(16'hFFFF));
                    break;
                end
                e = sb.pop_front();
                chk($sformatf("rnd_idx%0d", e.idx), W'(a_idx), W'(e.idx));
                chk($sformatf("rnd_vec%0d", e.idx), a_vec, e.vec);
                last = e;
            end
            tick();
        end
        a_ready = 1'b0;
    endtask

    initial begin
        entry_t       e;
        entry_t       last;
        logic [W-1:0] held;
        int           stall;

        rst = 1'b1; a_start = 1'b0; a_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
        held = '0; stall = 0; last = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  W'(a_busy),  W'(0));
        chk("rst_done",  W'(a_done),  W'(0));
        chk("rst_valid", W'(a_valid), W'(0));
        chk("rst_vec",   a_vec,       W'(0));
        chk("rst_idx",   W'(a_idx),   W'(0));

        rst = 1'b0; a_ready = 1'b1;
        tick();
        chk("idle_ready_ignored", W'(a_valid), W'(0));

        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("start_valid", W'(a_valid), W'(1));
        chk("start_busy",  W'(a_busy),  W'(1));
        chk("start_idx",   W'(a_idx),   W'(0));
        chk("start_vec",   a_vec,       W'(0));

        // Directed run: start pulsed at idx1, three stall cycles at idx2, otherwise back-to-back.
        push_run(NA);
        for (int c = 0; c < 200; c++) begin
            if (!a_valid) break;
            a_start = (a_idx == 16'd1);
            if (a_idx == 16'd2 && stall < 3) begin
                if (stall == 0) held = a_vec;
                else begin
                    chk("stall_vec", a_vec, held);
                    chk("stall_idx", W'(a_idx), W'(2));
                end
                a_ready = 1'b0;
                stall++;
            end else begin
                a_ready = 1'b1;
                if (sb.size() == 0) begin
                    chk("extra_vector", W'(a_idx), W'(16'hFFFF));
                    break;
                end
                e = sb.pop_front();
                chk($sformatf("idx%0d", e.idx), W'(a_idx), W'(e.idx));
                chk($sformatf("vec%0d", e.idx), a_vec, e.vec);
                if (e.idx == 16'd1) chk("idx1_ones", a_vec, {W{1'b1}});
                if (e.idx == 16'd2) chk("idx2_low64", W'(a_vec[63:0]), W'(64'h80200003_00000001));
                last = e;
            end
            tick();
        end
        a_start = 1'b0;
        chk("run_done",     W'(a_done),    W'(1));
        chk("run_valid",    W'(a_valid),   W'(0));
        chk("run_busy",     W'(a_busy),    W'(0));
        chk("done_idx",     W'(a_idx),     W'(NA - 1));
        chk("done_vec",     a_vec,         last.vec);
        chk("sb_empty",     W'(sb.size()), W'(0));

        a_ready = 1'b1;
        repeat (2) tick();
        chk("done_ready_ignored_idx", W'(a_idx),  W'(NA - 1));
        chk("done_sticky",            W'(a_done), W'(1));
        a_ready = 1'b0;

        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("restart_done",  W'(a_done),  W'(0));
        chk("restart_valid", W'(a_valid), W'(1));
        chk("restart_idx",   W'(a_idx),   W'(0));
        chk("restart_vec",   a_vec,       W'(0));

        // Run to idx5, then assert reset between clock edges.
        push_run(NA);
        drain(5, last);
        chk("reach_idx5", W'(a_idx), W'(5));
        #2 rst = 1'b1;
        #1;
        chk("async_valid", W'(a_valid), W'(0));
        chk("async_busy",  W'(a_busy),  W'(0));
        chk("async_done",  W'(a_done),  W'(0));
        chk("async_idx",   W'(a_idx),   W'(0));
        chk("async_vec",   a_vec,       W'(0));
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        a_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", W'(a_valid), W'(0));
        chk("post_rst_done",  W'(a_done),  W'(0));
        a_ready = 1'b0;

        // Full random-ready run from IDLE must reproduce the SEED stream.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        push_run(NA);
        drain(-1, last);
        chk("rnd_done",     W'(a_done),    W'(1));
        chk("rnd_last_idx", W'(last.idx),  W'(NA - 1));
        chk("rnd_sb_empty", W'(sb.size()), W'(0));

        // NVEC=2: only the two corner vectors, LFSR untouched.
        b_ready = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_idx0", W'(b_idx), W'(0));
        chk("b_vec0", b_vec,     W'(0));
        tick();
        chk("b_idx1", W'(b_idx), W'(1));
        chk("b_vec1", b_vec,     {W{1'b1}});
        tick();
        chk("b_done",  W'(b_done),  W'(1));
        chk("b_valid", W'(b_valid), W'(0));
        chk("b_idx_hold", W'(b_idx), W'(1));
        chk("b_lfsr_seed", W'(dut_b.lfsr_reg), W'(SEED));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
